dma_xfer_sched: RTL and testbench
=================================

// Module: dma_xfer_sched
// PURPOSE
//  Sequences the ping-pong DMA datapath (CPU 8-bit side <-> MEM 4-bit side) and shares it between two requesting channels.
//  Arbitrates round-robin, latches the winner's direction and byte length, and re-initialises the DMA with the correct mode.
//  Gates source valid / destination enable until the transfer length is reached, then pulses done.
//  Sits between the channel requesters and the DMA top-level handshake pins.
// PARAMETERS
//  LEN_W       16    width of byte-length fields (max transfer 2^LEN_W-8 bytes)
//  INIT_CYC    2     cycles dma_resetn is held low before RUN (min 1)
//  WDOG_CYC    1024  idle-beat cycles before abort (watchdog build only)
// PORTS
//  clk          in   1      clock, all logic on rising edge
//  resetn       in   1      asynchronous active-low reset
//  req          in   2      channel request, held until that channel's done
//  req_mode     in   2      per-channel direction: 1 = cpu_to_mem, 0 = mem_to_cpu
//  req_len0     in   LEN_W  channel 0 length in bytes
//  req_len1     in   LEN_W  channel 1 length in bytes
//  gnt          out  2      one-hot grant, high INIT..DONE
//  done         out  2      1-cycle completion pulse per channel
//  err          out  1      1-cycle abort pulse, coincident with done (watchdog build only; else tied 0)
//  busy         out  1      FSM not IDLE
//  dma_mode     out  1      mode to DMA, stable while dma_resetn low and throughout RUN
//  dma_resetn   out  1      DMA reset, low outside RUN/DRAIN
//  src_fire     in   1      source handshake completed this cycle (valid & enable, source side)
//  dst_fire     in   1      destination handshake completed this cycle
//  src_gate     out  1      ANDed into source-side valid by top level
//  dst_gate     out  1      ANDed into destination-side enable by top level
// BEHAVIOUR
//  Reset values: gnt=0, done=0, err=0, busy=0, dma_mode=0, dma_resetn=0, src_gate=0, dst_gate=0, rr pointer=ch0 preferred.
//  FSM: IDLE -> INIT -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: if any req, grant per rr (sole requester wins; both -> pointer ch); latch mode, len; go INIT.
//   rr pointer flips to the other channel when a grant is issued. len latched with [2:0] forced 0 (8-byte FIFO granule).
//   Latched len==0: skip INIT/RUN, go DONE directly.
//  INIT: dma_mode=latched mode, dma_resetn=0 for INIT_CYC cycles, then RUN.
//  Beat targets: cpu_to_mem src=len, dst=2*len; mem_to_cpu src=2*len, dst=len (nibble side counts 2 per byte).
//   Counters LEN_W+1 bits, cleared on entering INIT.
//  RUN: dma_resetn=1, src_gate=1 while src_cnt<src_tgt, dst_gate=1. src_fire/dst_fire each +1 their counter.
//   src_cnt reaching src_tgt -> DRAIN next cycle; src_gate drops the same cycle the final src_fire is seen (registered, 1-cycle lag tolerated; extra src_fire ignored).
//  DRAIN: src_gate=0, dst_gate=1 until dst_cnt==dst_tgt -> DONE.
//  DONE: 1 cycle, done[granted]=1, gnt still high, dma_resetn=0, gates 0; next IDLE, gnt=0.
//  Simultaneous src_fire and dst_fire in the same cycle: both counters advance.
//  req drop mid-transfer ignored; transfer completes. New req in DONE considered next IDLE cycle (min 1 IDLE cycle between grants).
//  resetn low at any state: immediate async return to reset values; no done pulse for aborted transfer.
// CONFIGURATION
//  DMA_XFER_SCHED_WDOG_EN defined: counter cleared on any src_fire/dst_fire and on entering RUN;
//   reaching WDOG_CYC in RUN/DRAIN -> DONE with err=1 alongside done.
//  Not defined: no watchdog counter, err tied 0, RUN/DRAIN wait indefinitely.
// TESTING
//  1 ch0 req, mode=1, len=16; src_fire every cycle, dst_fire every cycle -> INIT 2 cyc, 16 src beats, DRAIN until 32 dst beats, done[0] 1 cycle.
//  2 ch1 req, mode=0, len=8 -> src target 16, dst target 8; dma_mode=0 while dma_resetn low; done[1] after 8th dst_fire.
//  3 req=2'b11 both held, len=8 each -> grants ch0, ch1, ch0 alternately; never both gnt bits high.
//  4 len=13 -> treated as 8; len=5 -> immediate DONE, done pulse 1 cycle after grant, dma_resetn never high.
//  5 resetn low mid-RUN after 5 beats -> all outputs to reset values same cycle; after release, re-request restarts from 0.
//  6 WDOG_EN, WDOG_CYC=16, stop fires in RUN -> 16 cycles later done+err 1 cycle; without macro FSM stays RUN.

Source files
------------

// File: rtl/dma_xfer_sched.sv
// Two-channel round-robin scheduler that sequences the ping-pong DMA and gates beats to the latched length.
// Optional watchdog abort is built when DMA_XFER_SCHED_WDOG_EN is defined.
module dma_xfer_sched #(
   parameter int LEN_W    = 16,
   parameter int INIT_CYC = 2,
   parameter int WDOG_CYC = 1024
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [1:0]       req,
   input  logic [1:0]       req_mode,
   input  logic [LEN_W-1:0] req_len0,
   input  logic [LEN_W-1:0] req_len1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             err,
   output logic             busy,
   output logic             dma_mode,
   output logic             dma_resetn,
   input  logic             src_fire,
   input  logic             dst_fire,
   output logic             src_gate,
   output logic             dst_gate
);
   localparam int INIT_W = $clog2(INIT_CYC + 1);
   localparam logic [LEN_W:0] CNT_ONE = 1;

   typedef enum logic [2:0] {S_IDLE, S_INIT, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t             state_reg, state_next;
   logic               ch_reg, ch_next;
   logic               mode_reg, mode_next;
   logic               rr_reg, rr_next;
   logic [LEN_W-1:0]   len_reg, len_next;
   logic [INIT_W-1:0]  init_cnt_reg, init_cnt_next;
   logic [LEN_W:0]     src_cnt_reg, src_cnt_next;
   logic [LEN_W:0]     dst_cnt_reg, dst_cnt_next;
   logic [LEN_W:0]     src_tgt, dst_tgt;
   logic               win;
   logic [LEN_W-1:0]   win_len;
   logic               active;

`ifdef DMA_XFER_SCHED_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYC + 1);
   logic [WDOG_W-1:0]  wdog_cnt_reg, wdog_cnt_next;
   logic               abort_reg, abort_next;
`endif

   // The byte side counts one beat per byte, the nibble side two.
   assign src_tgt = mode_reg ? {1'b0, len_reg} : {len_reg, 1'b0};
   assign dst_tgt = mode_reg ? {len_reg, 1'b0} : {1'b0, len_reg};
   assign active  = (state_reg == S_RUN) || (state_reg == S_DRAIN);

   always_comb begin
      win = rr_reg;
      if (req == 2'b01) begin
         win = 1'b0;
      end else if (req == 2'b10) begin
         win = 1'b1;
      end
      win_len      = win ? req_len1 : req_len0;
      win_len[2:0] = 3'b000;
   end

   always_comb begin
      state_next    = state_reg;
      ch_next       = ch_reg;
      mode_next     = mode_reg;
      rr_next       = rr_reg;
      len_next      = len_reg;
      init_cnt_next = init_cnt_reg;
      src_cnt_next  = src_cnt_reg;
      dst_cnt_next  = dst_cnt_reg;
      gnt           = 2'b00;
      done          = 2'b00;
      busy          = (state_reg != S_IDLE);
      dma_mode      = mode_reg;
      dma_resetn    = active;
      src_gate      = (state_reg == S_RUN) && (src_cnt_reg < src_tgt);
      dst_gate      = active && (dst_cnt_reg < dst_tgt);
      if (state_reg != S_IDLE) begin
         gnt = ch_reg ? 2'b10 : 2'b01;
      end
      if (state_reg == S_DONE) begin
         done = gnt;
      end

      case (state_reg)
         S_IDLE: begin
            if (req != 2'b00) begin
               ch_next       = win;
               mode_next     = req_mode[win];
               rr_next       = ~win;
               len_next      = win_len;
               init_cnt_next = '0;
               src_cnt_next  = '0;
               dst_cnt_next  = '0;
               state_next    = (win_len == '0) ? S_DONE : S_INIT;
            end
         end
         S_INIT: begin
            init_cnt_next = init_cnt_reg + INIT_W'(1);
            if (init_cnt_reg == INIT_W'(INIT_CYC - 1)) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (src_fire && (src_cnt_reg < src_tgt)) begin
               src_cnt_next = src_cnt_reg + CNT_ONE;
            end
            if (src_cnt_reg == src_tgt) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (dst_cnt_reg == dst_tgt) begin
               state_next = S_DONE;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      if (active && dst_fire && (dst_cnt_reg < dst_tgt)) begin
         dst_cnt_next = dst_cnt_reg + CNT_ONE;
      end

`ifdef DMA_XFER_SCHED_WDOG_EN
      wdog_cnt_next = wdog_cnt_reg;
      abort_next    = abort_reg;
      if (state_reg == S_IDLE) begin
         abort_next = 1'b0;
      end
      if (state_reg == S_INIT) begin
         wdog_cnt_next = '0;
      end else if (active) begin
         // A stalled datapath overrides any normal transition.
         if (src_fire || dst_fire) begin
            wdog_cnt_next = '0;
         end else if (wdog_cnt_reg == WDOG_W'(WDOG_CYC - 1)) begin
            state_next = S_DONE;
            abort_next = 1'b1;
         end else begin
            wdog_cnt_next = wdog_cnt_reg + WDOG_W'(1);
         end
      end
`endif
   end

`ifdef DMA_XFER_SCHED_WDOG_EN
   assign err = (state_reg == S_DONE) && abort_reg;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg    <= S_IDLE;
         ch_reg       <= 1'b0;
         mode_reg     <= 1'b0;
         rr_reg       <= 1'b0;
         len_reg      <= '0;
         init_cnt_reg <= '0;
         src_cnt_reg  <= '0;
         dst_cnt_reg  <= '0;
`ifdef DMA_XFER_SCHED_WDOG_EN
         wdog_cnt_reg <= '0;
         abort_reg    <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         ch_reg       <= ch_next;
         mode_reg     <= mode_next;
         rr_reg       <= rr_next;
         len_reg      <= len_next;
         init_cnt_reg <= init_cnt_next;
         src_cnt_reg  <= src_cnt_next;
         dst_cnt_reg  <= dst_cnt_next;
`ifdef DMA_XFER_SCHED_WDOG_EN
         wdog_cnt_reg <= wdog_cnt_next;
         abort_reg    <= abort_next;
`endif
      end
   end
endmodule

// File: tb/tb_dma_xfer_sched.sv
// Randomised bench for dma_xfer_sched: transfer-level reference model compared every cycle,
// plus literal latency/order expectations for the directed scenarios.
module tb_dma_xfer_sched;
   localparam int LEN_W    = 16;
   localparam int INIT_CYC = 2;
   localparam int WDOG_CYC = 16;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic [1:0]       req = 2'b00;
   logic [1:0]       req_mode = 2'b00;
   logic [LEN_W-1:0] req_len0 = '0;
   logic [LEN_W-1:0] req_len1 = '0;
   logic [1:0]       gnt, done;
   logic             err, busy, dma_mode, dma_resetn, src_gate, dst_gate;
   logic             src_fire = 1'b0;
   logic             dst_fire = 1'b0;

   always #5 clk = ~clk;

   dma_xfer_sched #(.LEN_W(LEN_W), .INIT_CYC(INIT_CYC), .WDOG_CYC(WDOG_CYC)) dut (
      .clk(clk), .resetn(resetn), .req(req), .req_mode(req_mode),
      .req_len0(req_len0), .req_len1(req_len1), .gnt(gnt), .done(done), .err(err),
      .busy(busy), .dma_mode(dma_mode), .dma_resetn(dma_resetn),
      .src_fire(src_fire), .dst_fire(dst_fire), .src_gate(src_gate), .dst_gate(dst_gate)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // transfer-level reference model
   typedef enum int {M_IDLE, M_INIT, M_RUN, M_DRAIN, M_DONE} mphase_t;
   mphase_t ph = M_IDLE;
   int  m_ch = 0, m_mode = 0, m_len = 0, m_src = 0, m_dst = 0;
   int  m_src_tgt = 0, m_dst_tgt = 0, m_init_left = 0, m_wd = 0;
   bit  m_rr = 1'b0, m_err = 1'b0;

   logic [1:0] req_hold = 2'b00;
   bit         sticky = 1'b0;
   int         policy = 0;

   logic [1:0] prev_gnt = 2'b00;
   int         t_gnt = 0, last_lat = -1, err_cnt = 0;
   bit         saw_run = 1'b0;
   int         done_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      ph = M_IDLE; m_rr = 1'b0; m_mode = 0; m_err = 1'b0; m_src = 0; m_dst = 0;
      prev_gnt = 2'b00;
   endtask

   task automatic model_advance();
      mphase_t nxt;
      int w;
      nxt = ph;
      case (ph)
         M_IDLE: if (req != 2'b00) begin
            w = (req == 2'b11) ? int'(m_rr) : (req[1] ? 1 : 0);
            m_rr = (w == 0);
            m_ch = w;
            m_mode = int'(req_mode[w]);
            m_len = (w == 1 ? int'(req_len1) : int'(req_len0)) & ~7;
            m_src_tgt = m_mode ? m_len : 2 * m_len;
            m_dst_tgt = m_mode ? 2 * m_len : m_len;
            m_src = 0; m_dst = 0; m_err = 1'b0; m_init_left = INIT_CYC;
            nxt = (m_len == 0) ? M_DONE : M_INIT;
         end
         M_INIT: begin
            m_init_left--;
            if (m_init_left == 0) begin
               nxt = M_RUN;
               m_wd = 0;
            end
         end
         M_RUN, M_DRAIN: begin
            if (ph == M_RUN && m_src == m_src_tgt) nxt = M_DRAIN;
            if (ph == M_DRAIN && m_dst == m_dst_tgt) nxt = M_DONE;
            if (ph == M_RUN && src_fire && m_src < m_src_tgt) m_src++;
            if (dst_fire && m_dst < m_dst_tgt) m_dst++;
`ifdef DMA_XFER_SCHED_WDOG_EN
            if (src_fire || dst_fire) m_wd = 0;
            else if (m_wd == WDOG_CYC - 1) begin
               nxt = M_DONE;
               m_err = 1'b1;
            end else m_wd++;
`endif
         end
         M_DONE: nxt = M_IDLE;
         default: nxt = M_IDLE;
      endcase
      ph = nxt;
   endtask

   task automatic compare_outputs();
      logic [1:0] e_gnt;
      bit run;
      e_gnt = (ph == M_IDLE) ? 2'b00 : (m_ch == 1 ? 2'b10 : 2'b01);
      run = (ph == M_RUN) || (ph == M_DRAIN);
      chk("gnt", gnt, e_gnt);
      chk("done", done, (ph == M_DONE) ? e_gnt : 2'b00);
      chk("busy", busy, ph != M_IDLE);
      chk("dma_resetn", dma_resetn, run);
      chk("src_gate", src_gate, (ph == M_RUN) && (m_src < m_src_tgt));
      chk("dst_gate", dst_gate, run && (m_dst < m_dst_tgt));
      chk("err", err, (ph == M_DONE) && m_err);
      if (ph != M_IDLE) chk("dma_mode", dma_mode, m_mode);
      if (gnt != 2'b00 && prev_gnt == 2'b00) begin
         t_gnt = cyc;
         saw_run = 1'b0;
      end
      if (dma_resetn) saw_run = 1'b1;
      if (err) err_cnt++;
      if (done != 2'b00) begin
         last_lat = cyc - t_gnt;
         done_q.push_back(done[1] ? 1 : 0);
         $display("xfer ch=%0d mode=%0d len=%0d lat=%0d err=%0b cycle=%0d",
                  done[1] ? 1 : 0, m_mode, m_len, last_lat, err, cyc);
      end
      prev_gnt = gnt;
   endtask

   task automatic step();
      bit sg, dg, run;
      run = (ph == M_RUN) || (ph == M_DRAIN);
      sg = (ph == M_RUN) && (m_src < m_src_tgt);
      dg = run && (m_dst < m_dst_tgt);
      if (ph == M_DONE && !sticky) req_hold[m_ch] = 1'b0;
      req = req_hold;
      if (policy == 0) begin
         src_fire = sg;
         dst_fire = dg;
      end else if (policy == 1) begin
         src_fire = sg ? ($urandom_range(0, 1) == 1) : (run && $urandom_range(0, 7) == 0);
         dst_fire = dg && ($urandom_range(0, 1) == 1);
      end else begin
         src_fire = 1'b0;
         dst_fire = 1'b0;
      end
      model_advance();
      @(negedge clk);
      cyc++;
      compare_outputs();
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (ph != M_DONE && n < budget) begin
         step();
         n++;
      end
      total++;
      if (ph != M_DONE) begin
         bad++;
         $display("FAIL wait_done: no completion within %0d cycles (cycle %0d)", budget, cyc);
      end
      step();
   endtask

   task automatic chk_reset_vals();
      chk("rst_gnt", gnt, 0);          chk("rst_done", done, 0);
      chk("rst_err", err, 0);          chk("rst_busy", busy, 0);
      chk("rst_dma_mode", dma_mode, 0); chk("rst_dma_resetn", dma_resetn, 0);
      chk("rst_src_gate", src_gate, 0); chk("rst_dst_gate", dst_gate, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk_reset_vals();
      resetn = 1'b1;
      model_reset();
      repeat (2) step();

      // 1: ch0 cpu_to_mem 16 bytes, fires every gated cycle
      policy = 0; req_mode = 2'b01; req_len0 = 16; req_hold = 2'b01; last_lat = -1;
      wait_done(200);
      chk("t1_latency", last_lat, 35);
      chk("t1_channel", done_q[$], 0);

      // 2: ch1 mem_to_cpu 8 bytes, req dropped mid-transfer
      req_mode = 2'b00; req_len1 = 8; req_hold = 2'b10; last_lat = -1;
      repeat (6) step();
      req_hold = 2'b00;
      wait_done(200);
      chk("t2_latency", last_lat, 20);
      chk("t2_channel", done_q[$], 1);

      // 3: both held, alternating grants
      done_q.delete();
      sticky = 1'b1; req_len0 = 8; req_len1 = 8; req_mode = 2'($urandom_range(0, 3));
      req_hold = 2'b11;
      repeat (3) wait_done(300);
      sticky = 1'b0; req_hold = 2'b00;
      repeat (2) step();
      chk("t3_count", done_q.size(), 3);
      if (done_q.size() == 3) begin
         chk("t3_first", done_q[0], 0);
         chk("t3_second", done_q[1], 1);
         chk("t3_third", done_q[2], 0);
      end

      // 4: length granule rounding and zero-length skip
      req_mode = 2'b01; req_len0 = 13; req_hold = 2'b01; last_lat = -1;
      wait_done(200);
      chk("t4_len13_latency", last_lat, 19);
      req_len0 = 5; req_hold = 2'b01; last_lat = -1;
      wait_done(20);
      chk("t4_len5_latency", last_lat, 0);
      chk("t4_len5_no_run", saw_run, 0);

      // 5: async reset mid-RUN, then restart from zero
      req_mode = 2'b10; req_len1 = 16; req_hold = 2'b10;
      n = 0;
      while (!(ph == M_RUN && m_src >= 5) && n < 100) begin
         step();
         n++;
      end
      chk("t5_reached_run", (ph == M_RUN && m_src >= 5), 1);
      resetn = 1'b0;
      #1;
      chk_reset_vals();
      req_hold = 2'b00; req = 2'b00; src_fire = 1'b0; dst_fire = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (2) step();
      req_mode = 2'b01; req_len0 = 16; req_hold = 2'b01; last_lat = -1;
      wait_done(200);
      chk("t5_restart_latency", last_lat, 35);

      // 6: datapath stalls mid-RUN
      policy = 1; req_mode = 2'b01; req_len0 = 64; req_hold = 2'b01; err_cnt = 0;
      n = 0;
      while (!(ph == M_RUN && m_src >= 3) && n < 500) begin
         step();
         n++;
      end
      policy = 2;
      repeat (40) step();
`ifdef DMA_XFER_SCHED_WDOG_EN
      chk("t6_err_pulses", err_cnt, 1);
      policy = 1;
`else
      chk("t6_still_busy", busy, 1);
      chk("t6_still_run", dma_resetn, 1);
      policy = 1;
      wait_done(3000);
`endif

      // randomised traffic
      for (int i = 0; i < 40; i++) begin
         req_mode = 2'($urandom_range(0, 3));
         req_len0 = LEN_W'($urandom_range(0, 80));
         req_len1 = LEN_W'($urandom_range(0, 80));
         req_hold = req_hold | 2'($urandom_range(1, 3));
         wait_done(3000);
         repeat ($urandom_range(0, 2)) step();
      end
      req_hold = 2'b00;
      n = 0;
      while (ph != M_IDLE && n < 3000) begin
         step();
         n++;
      end
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
